bcd_serial_adder_ctrl: RTL and testbench

- Sequencer that adds two multi-digit packed-BCD operands by time-sharing one single-digit BCD adder stage, one digit per clock, least-significant digit first.
- The single-digit stage is combinational inside this block:
  - binary 4-bit add of the two digits plus carry-in;
  - add 6 (0110) when the binary sum exceeds 9 or produces a carry-out;
  - the decimal carry-out is the result of that same test.
- Sits between the operand/command source (switch/register interface) and the result display or register path; provides a start/done handshake.

---
 rtl/bcd_serial_adder_ctrl.sv | 154 +++++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder that reuses one combinational digit stage.
// It processes one digit per clock, least-significant digit first, behind a start/done handshake.
module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned IDXW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]      dig_a, dig_b, dig_sum;
  logic [4:0]      dig_bin;
  logic            dig_carry;
  logic            bad_digit;

  // Shared single-digit decimal stage on the currently indexed digit
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDXW'(i)) begin
        dig_a = opa_q[4*i +: 4];
        dig_b = opb_q[4*i +: 4];
      end
    end
    dig_bin   = 5'(dig_a) + 5'(dig_b) + 5'(carry_q);
    dig_carry = (dig_bin > 5'd9);
    dig_sum   = dig_carry ? 4'(dig_bin + 5'd6) : dig_bin[3:0];
  end

  // Operand validity check on the incoming (not yet latched) operands
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    unique case (state_q)
      // DONE returns to idle, so a start on its closing edge is accepted as from IDLE
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          if (bad_digit) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ADD;
          end
        end
      end
      ADD: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[4*i +: 4] = dig_sum;
          end
        end
        carry_d = dig_carry;
        if (idx_q == IDXW'(DIGITS - 1)) begin
          cout_d  = dig_carry;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl (DIGITS=4): latency, carry ripple, invalid digits,
// ignored start while busy, asynchronous reset mid-operation and back-to-back throughput.
module tb_bcd_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int total;
  int bad;

  bcd_serial_adder_ctrl #(.DIGITS(4), .IDXW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation, scramble inputs afterwards, and measure cycles to done.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                        output int lat, output int nb);
    a = xa; b = xb; cin = xc; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = ~xc;
    lat = -1;
    nb  = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) nb++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h want=0000", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, nb;
    run_op(16'h1234, 16'h5678, 1'b0, lat, nb);
    total++; if (lat != 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
    total++; if (nb != 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=4", nb); end
    total++; if (sum !== 16'h6912) begin bad++; $display("FAIL basic_sum got=%h want=6912", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", cout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", err); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    repeat (10) tick();
    total++; if (sum !== 16'h6912) begin bad++; $display("FAIL basic_sum_hold got=%h want=6912", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL basic_cout_hold got=%b want=0", cout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_carry();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] want_sum [3];
    logic        want_cout [3];
    int lat, nb;
    va = '{16'h9999, 16'h0000, 16'h5000};
    vb = '{16'h0001, 16'h9999, 16'h5000};
    vc = '{1'b0, 1'b1, 1'b0};
    want_sum  = '{16'h0000, 16'h0000, 16'h0000};
    want_cout = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], lat, nb);
      total++; if (lat != 4) begin bad++; $display("FAIL carry%0d_latency got=%0d want=4", i, lat); end
      total++; if (sum !== want_sum[i]) begin bad++; $display("FAIL carry%0d_sum got=%h want=%h", i, sum, want_sum[i]); end
      total++; if (cout !== want_cout[i]) begin bad++; $display("FAIL carry%0d_cout got=%b want=%b", i, cout, want_cout[i]); end
      tick();
    end
  endtask

  task automatic test_invalid();
    int lat, nb;
    run_op(16'h12A4, 16'h0000, 1'b0, lat, nb);
    total++; if (lat != 0) begin bad++; $display("FAIL invalid_latency got=%0d want=0", lat); end
    total++; if (nb != 0) begin bad++; $display("FAIL invalid_busy got=%0d want=0", nb); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL invalid_err got=%b want=1", err); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL invalid_sum got=%h want=0000", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL invalid_cout got=%b want=0", cout); end
    tick();
    run_op(16'h0001, 16'h0001, 1'b0, lat, nb);
    total++; if (lat != 4) begin bad++; $display("FAIL recover_latency got=%0d want=4", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL recover_err got=%b want=0", err); end
    total++; if (sum !== 16'h0002) begin bad++; $display("FAIL recover_sum got=%h want=0002", sum); end
    tick();
  endtask

  task automatic test_start_busy();
    int lat;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        a = 16'h9999; b = 16'h9999; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c;
        break;
      end
      tick();
    end
    start = 1'b0;
    total++; if (lat != 4) begin bad++; $display("FAIL busy_start_latency got=%0d want=4", lat); end
    total++; if (sum !== 16'h3333) begin bad++; $display("FAIL busy_start_sum got=%h want=3333", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL busy_start_cout got=%b want=0", cout); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL busy_start_extra_done got=%b want=0", done); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_queued got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    a = 16'h4567; b = 16'h4444; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL midrst_sum got=%h want=0000", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%b want=0", cout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", err); end
    #1 rst_n = 1'b1;
    tick();
    run_op(16'h0005, 16'h0005, 1'b0, lat, nb);
    total++; if (lat != 4) begin bad++; $display("FAIL postrst_latency got=%0d want=4", lat); end
    total++; if (sum !== 16'h0010) begin bad++; $display("FAIL postrst_sum got=%h want=0010", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL postrst_cout got=%b want=0", cout); end
    tick();
  endtask

  task automatic test_back_to_back();
    int prev, nd;
    a = 16'h0050; b = 16'h0050; cin = 1'b0; start = 1'b1;
    prev = -1;
    nd   = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (done) begin
        nd++;
        total++; if (sum !== 16'h0100) begin bad++; $display("FAIL b2b_sum t=%0d got=%h want=0100", t, sum); end
        if (prev >= 0) begin
          total++; if (t - prev != 5) begin bad++; $display("FAIL b2b_spacing got=%0d want=5", t - prev); end
        end
        prev = t;
      end
    end
    start = 1'b0;
    total++; if (nd != 4) begin bad++; $display("FAIL b2b_done_count got=%0d want=4", nd); end
    tick();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_carry();
    test_invalid();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
